tlu_tx_multi: RTL and testbench
===============================

TLU_TX_MULTI -- requirements
Module: tlu_tx_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent DUT trigger channels.
REQ-002 Parameter ID_WIDTH, default 15, trigger-ID bits shifted per handshake.
REQ-003 Parameter CNT_WIDTH, default 16, timeout counter width.
REQ-004 SYS_CLK  in  1  sole clock; all logic is on its rising edge.
REQ-005 SYS_RST_N  in  1  asynchronous, active-low reset.
REQ-006 ENABLE_MASK  in  N_CH  per-channel enable.
REQ-007 MODE  in  2*N_CH  per-channel mode: 0 = PULSE, 1 = HANDSHAKE, 2 = ID_HANDSHAKE, 3 = treated as PULSE.
REQ-008 TRIG  in  1  single-cycle trigger request; TRIG_ID  in  ID_WIDTH  ID captured with TRIG.
REQ-009 TRIG_LEN  in  8  pulse length in cycles for PULSE mode and TLU reset; 0 is treated as 1.
REQ-010 TIMEOUT  in  CNT_WIDTH  maximum wait cycles per handshake phase; 0 disables timeout.
REQ-011 RESET_REQ  in  1  single-cycle request for a TLU_RESET pulse on enabled channels.
REQ-012 ERR_CLR  in  1  clears TIMEOUT_ERR.
REQ-013 TLU_CLOCK, TLU_BUSY  in  N_CH  asynchronous DUT inputs.
REQ-014 TLU_TRIGGER, TLU_RESET  out  N_CH  registered outputs to the DUTs.
REQ-015 READY  out  1; TRIG_DROPPED  out  1 (single-cycle pulse); TIMEOUT_ERR  out  N_CH (sticky).

Function
REQ-016 Each TLU_CLOCK and TLU_BUSY bit SHALL pass through a 2-FF synchroniser before use; logic sees only the synchronised values (sclk, sbusy).
REQ-017 Per-channel FSM states: IDLE, TRIG, SHIFT, RELEASE, RST.
REQ-018 READY SHALL be 1 when ENABLE_MASK == 0; otherwise 1 only if every enabled channel is IDLE and every enabled ID_HANDSHAKE channel has sclk == 0.
REQ-019 An accept is TRIG & READY & !RESET_REQ; TRIG without an accept SHALL pulse TRIG_DROPPED for one cycle.
REQ-020 On accept, each enabled channel SHALL latch TRIG_ID and MODE and enter TRIG; TLU_TRIGGER rises on the next cycle.
REQ-021 PULSE: TLU_TRIGGER high exactly TRIG_LEN cycles, then IDLE; sbusy is ignored.
REQ-022 HANDSHAKE / ID_HANDSHAKE in TRIG: TLU_TRIGGER high until sbusy == 1; the next state is RELEASE or SHIFT, respectively, with TLU_TRIGGER = 0.
REQ-023 SHIFT: on the k-th sclk rising edge (k = 1..ID_WIDTH), TLU_TRIGGER SHALL take ID[k-1] one cycle later (LSB first); after ID_WIDTH edges, TLU_TRIGGER = 0 and further edges are ignored.
REQ-024 SHIFT/RELEASE: sbusy == 0 returns the channel to IDLE with TLU_TRIGGER = 0, even if fewer than ID_WIDTH bits were sent.
REQ-025 Timeout: a per-channel counter clears on each state entry and increments in TRIG, SHIFT and RELEASE; when it reaches TIMEOUT (≠ 0), the channel SHALL set TIMEOUT_ERR, drive TLU_TRIGGER to 0 and return to IDLE.
REQ-026 RESET_REQ when all enabled channels are IDLE: enabled channels enter RST, TLU_RESET high TRIG_LEN cycles, then IDLE; RESET_REQ at any other time is ignored.
REQ-027 RESET_REQ and TRIG in the same cycle: RESET_REQ wins, and TRIG counts as dropped.
REQ-028 Clearing a channel's ENABLE_MASK bit mid-operation SHALL abort that channel to IDLE on the next cycle with outputs at 0 and no error set.
REQ-029 ERR_CLR and a timeout event in the same cycle: the set wins.
REQ-030 MODE and TRIG_LEN changes mid-operation SHALL NOT affect the transaction in progress.

Reset
REQ-031 While SYS_RST_N == 0: all FSMs IDLE; TLU_TRIGGER, TLU_RESET, TIMEOUT_ERR, TRIG_DROPPED and the synchronisers at 0; counters at 0.
REQ-032 READY SHALL follow REQ-018 from the first clock after reset release.

Structure
REQ-033 Package tlu_pkg SHALL hold the mode encodings and the channel state enum.
REQ-034 Sub-module tlu_tx_ch SHALL implement one channel (synchroniser, FSM, shifter, timeout); the top SHALL instantiate it N_CH times and build READY, accept and the drop logic.

Verification
REQ-035 PULSE, TRIG_LEN = 3, TRIG: TLU_TRIGGER high exactly 3 cycles, starting 1 cycle after TRIG; READY low throughout.
REQ-036 ID_HANDSHAKE, TRIG_ID = 0x5A5A, DUT raises BUSY then toggles TLU_CLOCK 15 times: TLU_TRIGGER drops after BUSY, serial bits are 0,1,0,1,1,0,1,0,0,1,0,1,1,0,1 LSB first, and the channel is IDLE after BUSY falls.
REQ-037 HANDSHAKE, TIMEOUT = 100, DUT never asserts BUSY: TLU_TRIGGER high ~100 cycles, then 0; TIMEOUT_ERR set; ERR_CLR clears it.
REQ-038 N_CH = 4, mask 0b0101, mixed modes, TRIG: only channels 0 and 2 respond; READY returns only after both are IDLE; a second TRIG while busy gives TRIG_DROPPED = 1.
REQ-039 RESET_REQ and TRIG in the same cycle while idle, TRIG_LEN = 2: TLU_RESET is a 2-cycle pulse, no TLU_TRIGGER, TRIG_DROPPED = 1.
REQ-040 SYS_RST_N low mid-SHIFT: all outputs 0 immediately (asynchronous); after release READY = 1 with DUT inputs idle.

Source files
------------

// File: rtl/tlu_tx_multi_pkg.sv
// Shared encodings for the multi-channel TLU trigger transmitter.
// Holds the per-channel mode values, the channel state enum and a small TRIG_LEN helper.
package tlu_pkg;

  typedef enum logic [1:0] {
    MODE_PULSE        = 2'd0,
    MODE_HANDSHAKE    = 2'd1,
    MODE_ID_HANDSHAKE = 2'd2,
    MODE_PULSE_ALT    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RST     = 3'd4
  } ch_state_e;

  // A zero pulse length is stretched to one cycle.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/tlu_tx_multi_if.sv
// DUT-side TLU bus: trigger/reset towards the DUTs, clock/busy back from them.
interface tlu_tx_multi_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] tlu_trigger;
  logic [N_CH-1:0] tlu_reset;
  logic [N_CH-1:0] tlu_clock;
  logic [N_CH-1:0] tlu_busy;

  modport master (output tlu_trigger, output tlu_reset, input tlu_clock, input tlu_busy);
  modport slave  (input tlu_trigger, input tlu_reset, output tlu_clock, output tlu_busy);
endinterface

// File: rtl/tlu_tx_ch.sv
// One TLU channel: input synchronisers, trigger/reset FSM, LSB-first ID shifter
// and the per-phase timeout counter.
module tlu_tx_ch
  import tlu_pkg::*;
#(
  parameter int unsigned ID_WIDTH  = 15,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic                 rst_start,
  input  logic [1:0]           mode,
  input  logic [ID_WIDTH-1:0]  trig_id,
  input  logic [7:0]           trig_len,
  input  logic [CNT_WIDTH-1:0] timeout,
  input  logic                 err_clr,
  input  logic                 tlu_clock,
  input  logic                 tlu_busy,
  output logic                 tlu_trigger,
  output logic                 tlu_reset,
  output logic                 timeout_err,
  output logic                 idle,
  output logic                 sclk
);

  localparam int unsigned CW = (CNT_WIDTH > 8) ? CNT_WIDTH : 8;
  localparam int unsigned BW = $clog2(ID_WIDTH + 1);

  ch_state_e           state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                trig_q, trig_d;
  logic                rst_q, rst_d;
  logic                err_q, err_d;
  logic [1:0]          clk_sync_q, clk_sync_d;
  logic [1:0]          busy_sync_q, busy_sync_d;
  logic                sclk_prev_q, sclk_prev_d;

  logic          sbusy, sclk_rise, sclk_fall, pulse_mode, to_hit, len_hit;
  logic [CW-1:0] cnt_inc;

  assign sbusy      = busy_sync_q[1];
  assign sclk_rise  = clk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall  = ~clk_sync_q[1] & sclk_prev_q;
  assign pulse_mode = (mode_q != MODE_HANDSHAKE) && (mode_q != MODE_ID_HANDSHAKE);
  assign cnt_inc    = cnt_q + CW'(1);
  assign to_hit     = (timeout != '0) && (cnt_inc == CW'(timeout));
  assign len_hit    = (cnt_inc == CW'(len_q));

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], tlu_clock};
    busy_sync_d = {busy_sync_q[0], tlu_busy};
    sclk_prev_d = clk_sync_q[1];
    state_d     = state_q;
    mode_d      = mode_q;
    id_d        = id_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    trig_d      = trig_q;
    rst_d       = rst_q;
    err_d       = err_q;
    if (err_clr) err_d = 1'b0;

    if (!en) begin
      // Disabling a channel aborts silently, without flagging an error.
      state_d = ST_IDLE;
      trig_d  = 1'b0;
      rst_d   = 1'b0;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rst_start) begin
            state_d = ST_RST;
            rst_d   = 1'b1;
            cnt_d   = '0;
            len_d   = eff_len(trig_len);
          end else if (start) begin
            state_d = ST_TRIG;
            trig_d  = 1'b1;
            cnt_d   = '0;
            bit_d   = '0;
            mode_d  = mode_e'(mode);
            id_d    = trig_id;
            len_d   = eff_len(trig_len);
          end
        end
        ST_TRIG: begin
          if (to_hit) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else if (pulse_mode) begin
            if (len_hit) begin
              state_d = ST_IDLE;
              trig_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (sbusy) begin
            state_d = (mode_q == MODE_ID_HANDSHAKE) ? ST_SHIFT : ST_RELEASE;
            trig_d  = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_SHIFT: begin
          if (to_hit) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else if (!sbusy) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            // Last bit is held until the following sclk fall; later edges do nothing.
            if (sclk_rise && (bit_q < BW'(ID_WIDTH))) begin
              trig_d = id_q[0];
              id_d   = id_q >> 1;
              bit_d  = bit_q + BW'(1);
            end else if (sclk_fall && (bit_q == BW'(ID_WIDTH))) begin
              trig_d = 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          if (to_hit) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else if (!sbusy) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RST: begin
          if (len_hit) begin
            state_d = ST_IDLE;
            rst_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
          rst_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_PULSE;
      id_q        <= '0;
      len_q       <= 8'd1;
      cnt_q       <= '0;
      bit_q       <= '0;
      trig_q      <= 1'b0;
      rst_q       <= 1'b0;
      err_q       <= 1'b0;
      clk_sync_q  <= '0;
      busy_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      id_q        <= id_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      trig_q      <= trig_d;
      rst_q       <= rst_d;
      err_q       <= err_d;
      clk_sync_q  <= clk_sync_d;
      busy_sync_q <= busy_sync_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign tlu_trigger = trig_q;
  assign tlu_reset   = rst_q;
  assign timeout_err = err_q;
  assign idle        = (state_q == ST_IDLE);
  assign sclk        = clk_sync_q[1];

endmodule

// File: rtl/tlu_tx_multi.sv
// Multi-channel TLU trigger transmitter: fans one trigger/reset request out to
// N_CH independent DUT channels and arbitrates READY / accept / drop.
module tlu_tx_multi
  import tlu_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ID_WIDTH  = 15,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 SYS_CLK,
  input  logic                 SYS_RST_N,
  input  logic [N_CH-1:0]      ENABLE_MASK,
  input  logic [2*N_CH-1:0]    MODE,
  input  logic                 TRIG,
  input  logic [ID_WIDTH-1:0]  TRIG_ID,
  input  logic [7:0]           TRIG_LEN,
  input  logic [CNT_WIDTH-1:0] TIMEOUT,
  input  logic                 RESET_REQ,
  input  logic                 ERR_CLR,
  tlu_tx_multi_if.master       tlu,
  output logic                 READY,
  output logic                 TRIG_DROPPED,
  output logic [N_CH-1:0]      TIMEOUT_ERR
);

  logic [N_CH-1:0] idle_v, sclk_v, trig_v, rst_v, err_v;
  logic            ready_c, all_idle_c, accept_c, rst_start_c;
  logic            dropped_q, dropped_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tlu_tx_ch #(
      .ID_WIDTH  (ID_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk         (SYS_CLK),
      .rst_n       (SYS_RST_N),
      .en          (ENABLE_MASK[i]),
      .start       (accept_c),
      .rst_start   (rst_start_c),
      .mode        (MODE[2*i +: 2]),
      .trig_id     (TRIG_ID),
      .trig_len    (TRIG_LEN),
      .timeout     (TIMEOUT),
      .err_clr     (ERR_CLR),
      .tlu_clock   (tlu.tlu_clock[i]),
      .tlu_busy    (tlu.tlu_busy[i]),
      .tlu_trigger (trig_v[i]),
      .tlu_reset   (rst_v[i]),
      .timeout_err (err_v[i]),
      .idle        (idle_v[i]),
      .sclk        (sclk_v[i])
    );
  end

  // ID_HANDSHAKE DUTs must have returned their clock low before a new trigger.
  always_comb begin
    ready_c    = 1'b1;
    all_idle_c = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (ENABLE_MASK[i]) begin
        if (!idle_v[i]) begin
          ready_c    = 1'b0;
          all_idle_c = 1'b0;
        end
        if ((MODE[2*i +: 2] == MODE_ID_HANDSHAKE) && sclk_v[i]) ready_c = 1'b0;
      end
    end
  end

  assign accept_c    = TRIG & ready_c & ~RESET_REQ;
  assign rst_start_c = RESET_REQ & all_idle_c;
  assign dropped_d   = TRIG & ~accept_c;

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) dropped_q <= 1'b0;
    else            dropped_q <= dropped_d;
  end

  assign READY           = ready_c;
  assign TRIG_DROPPED    = dropped_q;
  assign TIMEOUT_ERR     = err_v;
  assign tlu.tlu_trigger = trig_v;
  assign tlu.tlu_reset   = rst_v;

endmodule

// File: tb/tb_tlu_tx_multi.sv
// Directed bench for tlu_tx_multi: pulse, ID handshake, timeout, masking,
// reset request and asynchronous reset scenarios.
module tb_tlu_tx_multi;
  import tlu_pkg::*;

  localparam int unsigned N_CH = 4;
  localparam int unsigned IDW  = 15;
  localparam int unsigned CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] enable_mask;
  logic [2*N_CH-1:0] mode;
  logic            trig;
  logic [IDW-1:0]  trig_id;
  logic [7:0]      trig_len;
  logic [CNTW-1:0] timeout;
  logic            reset_req;
  logic            err_clr;
  logic            ready;
  logic            trig_dropped;
  logic [N_CH-1:0] timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  tlu_tx_multi_if #(.N_CH(N_CH)) tlu_bus ();

  tlu_tx_multi #(.N_CH(N_CH), .ID_WIDTH(IDW), .CNT_WIDTH(CNTW)) dut (
    .SYS_CLK      (clk),
    .SYS_RST_N    (rst_n),
    .ENABLE_MASK  (enable_mask),
    .MODE         (mode),
    .TRIG         (trig),
    .TRIG_ID      (trig_id),
    .TRIG_LEN     (trig_len),
    .TIMEOUT      (timeout),
    .RESET_REQ    (reset_req),
    .ERR_CLR      (err_clr),
    .tlu          (tlu_bus.master),
    .READY        (ready),
    .TRIG_DROPPED (trig_dropped),
    .TIMEOUT_ERR  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [14:0] exp_bits;
    int          hi_cnt;

    // 0x5A5A serialised LSB first: 0,1,0,1,1,0,1,0,0,1,0,1,1,0,1
    exp_bits = 15'h5A5A;

    rst_n = 1'b0; enable_mask = '0; mode = '0; trig = 1'b0; trig_id = '0;
    trig_len = 8'd3; timeout = '0; reset_req = 1'b0; err_clr = 1'b0;
    tlu_bus.tlu_clock = '0; tlu_bus.tlu_busy = '0;
    #23;
    chk("rst_trigger", 32'(tlu_bus.tlu_trigger), 32'h0);
    chk("rst_reset",   32'(tlu_bus.tlu_reset),   32'h0);
    chk("rst_err",     32'(timeout_err),         32'h0);
    chk("rst_dropped", 32'(trig_dropped),        32'h0);
    rst_n = 1'b1;
    tick();
    chk("ready_mask0", 32'(ready), 32'h1);

    // PULSE, TRIG_LEN = 3
    enable_mask = 4'b0001; mode = 8'h00;
    tick();
    chk("pulse_ready_before", 32'(ready), 32'h1);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("pulse_trig_c%0d", i), 32'(tlu_bus.tlu_trigger), (i <= 3) ? 32'h1 : 32'h0);
      chk($sformatf("pulse_ready_c%0d", i), 32'(ready), (i <= 3) ? 32'h0 : 32'h1);
      tick();
    end
    chk("pulse_no_drop", 32'(trig_dropped), 32'h0);

    // ID_HANDSHAKE, ID 0x5A5A
    mode = 8'h02; trig_id = 15'h5A5A; timeout = '0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("idhs_trig_high", 32'(tlu_bus.tlu_trigger), 32'h1);
    tlu_bus.tlu_busy = 4'b0001;
    ticks(4);
    chk("idhs_trig_drop_on_busy", 32'(tlu_bus.tlu_trigger), 32'h0);
    for (int k = 0; k < 15; k++) begin
      tlu_bus.tlu_clock = 4'b0001;
      ticks(4);
      chk($sformatf("idhs_bit%0d_hi", k), 32'(tlu_bus.tlu_trigger), 32'(exp_bits[k]));
      tlu_bus.tlu_clock = 4'b0000;
      ticks(4);
      chk($sformatf("idhs_bit%0d_lo", k), 32'(tlu_bus.tlu_trigger),
          (k == 14) ? 32'h0 : 32'(exp_bits[k]));
    end
    chk("idhs_ready_busy", 32'(ready), 32'h0);
    tlu_bus.tlu_clock = 4'b0001;
    ticks(4);
    chk("idhs_extra_edge", 32'(tlu_bus.tlu_trigger), 32'h0);
    tlu_bus.tlu_clock = 4'b0000;
    ticks(4);
    tlu_bus.tlu_busy = 4'b0000;
    ticks(4);
    chk("idhs_idle_ready", 32'(ready), 32'h1);
    chk("idhs_idle_trig", 32'(tlu_bus.tlu_trigger), 32'h0);

    // HANDSHAKE with TIMEOUT = 100, BUSY never raised
    mode = 8'h01; timeout = 16'd100;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (tlu_bus.tlu_trigger[0] !== 1'b1) break;
      hi_cnt++;
      tick();
    end
    chk("to_high_cycles", 32'(hi_cnt), 32'd100);
    chk("to_trig_low", 32'(tlu_bus.tlu_trigger), 32'h0);
    chk("to_err_set", 32'(timeout_err), 32'h1);
    chk("to_ready", 32'(ready), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 32'h0);
    timeout = '0;

    // Mask 0101, ch0 PULSE, ch2 HANDSHAKE; disabled channels in other modes
    enable_mask = 4'b0101; mode = {2'd2, 2'd1, 2'd1, 2'd0}; trig_len = 8'd3;
    trig = 1'b1;
    tick();
    chk("mask_trig_start", 32'(tlu_bus.tlu_trigger), 32'h5);
    chk("mask_ready_low", 32'(ready), 32'h0);
    tick();
    trig = 1'b0;
    chk("mask_drop_pulse", 32'(trig_dropped), 32'h1);
    chk("mask_trig_c2", 32'(tlu_bus.tlu_trigger), 32'h5);
    tick();
    chk("mask_drop_single", 32'(trig_dropped), 32'h0);
    tick();
    chk("mask_ch0_done", 32'(tlu_bus.tlu_trigger), 32'h4);
    chk("mask_ready_ch2_busy", 32'(ready), 32'h0);
    tlu_bus.tlu_busy = 4'b0100;
    ticks(4);
    chk("mask_ch2_release", 32'(tlu_bus.tlu_trigger), 32'h0);
    chk("mask_ready_release", 32'(ready), 32'h0);
    tlu_bus.tlu_busy = 4'b0000;
    ticks(4);
    chk("mask_ready_back", 32'(ready), 32'h1);

    // RESET_REQ with TRIG, TRIG_LEN = 2
    trig_len = 8'd2;
    reset_req = 1'b1; trig = 1'b1;
    tick();
    reset_req = 1'b0; trig = 1'b0;
    chk("rr_reset_c1", 32'(tlu_bus.tlu_reset), 32'h5);
    chk("rr_no_trig", 32'(tlu_bus.tlu_trigger), 32'h0);
    chk("rr_dropped", 32'(trig_dropped), 32'h1);
    tick();
    chk("rr_reset_c2", 32'(tlu_bus.tlu_reset), 32'h5);
    tick();
    chk("rr_reset_end", 32'(tlu_bus.tlu_reset), 32'h0);
    chk("rr_no_trig_end", 32'(tlu_bus.tlu_trigger), 32'h0);

    // Clearing the enable mid-handshake aborts without an error
    enable_mask = 4'b0001; mode = 8'h01; trig_len = 8'd3;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("abort_trig_high", 32'(tlu_bus.tlu_trigger), 32'h1);
    enable_mask = 4'b0000;
    tick();
    chk("abort_trig_low", 32'(tlu_bus.tlu_trigger), 32'h0);
    chk("abort_no_err", 32'(timeout_err), 32'h0);
    enable_mask = 4'b0001;
    tick();
    chk("abort_ready", 32'(ready), 32'h1);

    // Asynchronous reset in the middle of an ID shift
    mode = 8'h02; trig_id = 15'h5A5A;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tlu_bus.tlu_busy = 4'b0001;
    ticks(4);
    for (int k = 0; k < 2; k++) begin
      tlu_bus.tlu_clock = 4'b0001;
      ticks(4);
      if (k == 0) begin
        tlu_bus.tlu_clock = 4'b0000;
        ticks(4);
      end
    end
    chk("ar_bit1_high", 32'(tlu_bus.tlu_trigger), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_trig_zero", 32'(tlu_bus.tlu_trigger), 32'h0);
    chk("ar_reset_zero", 32'(tlu_bus.tlu_reset), 32'h0);
    chk("ar_err_zero", 32'(timeout_err), 32'h0);
    tlu_bus.tlu_clock = '0; tlu_bus.tlu_busy = '0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("ar_ready_after", 32'(ready), 32'h1);
    chk("ar_trig_after", 32'(tlu_bus.tlu_trigger), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
